// File: rtl/tl_sensor_cond.sv
// Detector conditioning for the left-turn traffic-light controller.
// Each of the four lanes (a, al, b, bl) runs a 2-FF synchroniser, a
// run-length debouncer and a request latch. The latch holds a request
// until the controller's light code shows that lane is being served.
// Lane order in all packed vectors is {bl, b, al, a}.
module tl_sensor_cond #(
  parameter int          DEB_CYC = 4,
  parameter int          CW      = 8,
  parameter logic [1:0]  GREEN   = 2'b00,
  parameter logic [1:0]  LEFT    = 2'b11
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       raw_a,
  input  logic       raw_al,
  input  logic       raw_b,
  input  logic       raw_bl,
  input  logic [1:0] La,
  input  logic [1:0] Lb,
  output logic       Ta,
  output logic       Tal,
  output logic       Tb,
  output logic       Tbl
);

  // Terminal count: the DEB_CYC-th consecutive disagreement flips deb.
  localparam logic [CW-1:0] CNT_MAX = CW'(DEB_CYC - 1);

  logic [3:0]    raw;
  logic [3:0]    served;
  logic [3:0]    s1_q, s1_d;
  logic [3:0]    s2_q, s2_d;
  logic [3:0]    deb_q, deb_d;
  logic [3:0]    pend_q, pend_d;
  logic [CW-1:0] cnt_q [4];
  logic [CW-1:0] cnt_d [4];

  assign raw = {raw_bl, raw_b, raw_al, raw_a};

  // A lane counts as served only for its own exact light code; yellow,
  // red and any other code leave pending requests untouched.
  assign served = {(Lb == LEFT), (Lb == GREEN), (La == LEFT), (La == GREEN)};

  // Synchroniser shift and debounce counter: any agreement between the
  // synchronised level and deb restarts the count, so short glitches vanish.
  always_comb begin
    s1_d  = raw;
    s2_d  = s1_q;
    deb_d = deb_q;
    for (int i = 0; i < 4; i++) begin
      cnt_d[i] = cnt_q[i];
      if (s2_q[i] == deb_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_MAX) begin
        deb_d[i] = s2_q[i];
        cnt_d[i] = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + CW'(1);
      end
    end
  end

  // Request latch: set on a debounced rising edge, cleared whenever the
  // lane is served; clearing wins when both happen on the same edge.
  always_comb begin
    pend_d = pend_q;
    for (int i = 0; i < 4; i++) begin
      if (served[i]) begin
        pend_d[i] = 1'b0;
      end else if (!deb_q[i] && deb_d[i]) begin
        pend_d[i] = 1'b1;
      end
    end
  end

  // State registers; reset clears every lane immediately.
  always_ff @(posedge clk or posedge reset_n) begin
    if (reset_n) begin
      s1_q   <= '0;
      s2_q   <= '0;
      deb_q  <= '0;
      pend_q <= '0;
      for (int i = 0; i < 4; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      s1_q   <= s1_d;
      s2_q   <= s2_d;
      deb_q  <= deb_d;
      pend_q <= pend_d;
      for (int i = 0; i < 4; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  // Outputs are an OR of registers only, so raw-input bounce never
  // reaches the controller.
  assign Ta  = deb_q[0] | pend_q[0];
  assign Tal = deb_q[1] | pend_q[1];
  assign Tb  = deb_q[2] | pend_q[2];
  assign Tbl = deb_q[3] | pend_q[3];

endmodule

// File: doc/tl_sensor_cond.md
Name: tl_sensor_cond

Overview:
Conditions the four raw vehicle-detector inputs into the clean traffic requests Ta, Tal, Tb and Tbl for the left-turn traffic-light controller, which sits directly downstream.
Per lane it synchronises, debounces and latches the request. A latched request is held until the controller's light outputs show that the lane has been served.
La/Lb from the controller are fed back so that pending requests can be cleared.

Parameters:
DEB_CYC, 4, consecutive stable cycles required before the debounced level flips (legal range 1..2^CW-1)
CW, 8, debounce counter width
GREEN, 2'b00, light code meaning through-green
LEFT, 2'b11, light code meaning left-arrow

Ports:
clk  input  1  system clock, rising edge
reset_n  input  1  reset; asynchronous, active-high (asserted = 1 despite the name)
raw_a  input  1  raw detector, street A through, asynchronous, may bounce
raw_al  input  1  raw detector, street A left
raw_b  input  1  raw detector, street B through
raw_bl  input  1  raw detector, street B left
La  input  2  controller light state, street A
Lb  input  2  controller light state, street B
Ta  output  1  conditioned request, A through
Tal  output  1  conditioned request, A left
Tb  output  1  conditioned request, B through
Tbl  output  1  conditioned request, B left

Behaviour:
- Four identical lanes (a, al, b, bl), each with these registers:
  - s1, s2: 2-FF synchroniser.
  - cnt[CW-1:0]: debounce counter.
  - deb: debounced level.
  - pend: latched request.
- Reset (async, reset_n=1): s1=s2=0, cnt=0, deb=0, pend=0 for every lane; all T outputs = 0 immediately. Deassertion is taken at the next clk edge.
- Synchroniser: s1<=raw, s2<=s1.
- Debounce, per edge:
  - If s2==deb: cnt<=0.
  - Else if cnt==DEB_CYC-1: deb<=s2, cnt<=0.
  - Else: cnt<=cnt+1.
  - A disagreement shorter than DEB_CYC cycles is discarded, because cnt restarts at 0.
- Latency: raw high set up before edge k gives s2=1 after edge k+1 and deb=1 after edge k+1+DEB_CYC. With DEB_CYC=4, that is after edge 5. Release has the same latency.
- Served condition, decoded combinationally from the current La/Lb:
  - a served when La==GREEN.
  - al served when La==LEFT.
  - b served when Lb==GREEN.
  - bl served when Lb==LEFT.
- pend update:
  - Set on the edge where deb rises 0->1 while the lane is not served.
  - Cleared on any edge where the lane is served.
  - If set and served coincide, clear wins and pend stays 0.
  - Otherwise pend holds.
- Output: T = deb | pend, a combinational OR of registers, so it is glitch-free with respect to the raw inputs.
- Boundary cases:
  - Vehicle arrives and leaves before being served: pend keeps T=1 after deb drops, until the served code appears.
  - Vehicle present while served: T follows deb only; no pend is left behind.
  - La/Lb codes other than GREEN/LEFT (yellow, red, undefined) never clear pend.
  - DEB_CYC=1: deb flips on the first edge after s2 disagrees.
  - cnt never exceeds DEB_CYC-1, so there is no wrap-around.
  - Reset mid-debounce or with pend=1: all state is lost and T drops to 0 immediately.
  - Lanes are fully independent; simultaneous activity on all four lanes must behave as four separate instances.

Test Plan:
1. Reset and latency: reset_n=1 for 3 cycles, then 0; raw_a=1 held, La=2'b10 (red), DEB_CYC=4 -> Ta=0 through edge 4 after raw_a rises, Ta=1 after edge 5. Tal, Tb and Tbl stay 0 throughout.
2. Glitch rejection: raw_b pulses high for 3 cycles, then low, DEB_CYC=4 -> Tb stays 0 and cnt returns to 0. A 4-cycle pulse produces Tb=1.
3. Latching and clear: raw_al high for 6 cycles, then low, La=red -> Tal stays 1 after the debounced release. Then La=LEFT for 1 cycle -> Tal=0 on the following edge and stays 0 once La returns to red.
4. Served while present: Lb=GREEN, raw_bl inactive, raw_b rises -> Tb rises after the debounce and falls with deb after release, with pend=0 throughout. Simultaneous set and served -> pend remains 0.
5. Mid-operation reset: pend=1 on all four lanes, then pulse reset_n=1 for part of a cycle asynchronously -> all T=0 at once, and no output asserts again until a fresh debounce completes.
6. Concurrency: all four raw inputs toggled with staggered timing while La/Lb cycle GREEN -> yellow (2'b01) -> red -> LEFT -> each T matches an independent single-lane reference model cycle by cycle.
